// File: rtl/net_cmd_sequencer_pkg.sv
// Shared widths, opcodes, command record and sequencer FSM states for net_cmd_sequencer.
package net_cmd_sequencer_pkg;

    localparam int IMEM_ADDR_W = 10;
    localparam int DMEM_ADDR_W = 10;
    localparam int DATA_W      = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CMD_NOP     = 3'd0,
        CMD_IMEM_WR = 3'd1,
        CMD_DMEM_WR = 3'd2,
        CMD_PC_WR   = 3'd3
    } net_cmd_e;

    // Raw 3-bit opcode so the undefined opcodes 4..7 survive buffering and can be dropped.
    typedef struct packed {
        logic [2:0]             cmd;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]      data;
    } net_cmd_s;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ISSUE = 2'd1,
        S_BLOCK = 2'd2
    } seq_state_e;

endpackage

// File: rtl/net_cmd_sequencer_if.sv
// Network command handshake: valid/opcode/address/payload towards the sequencer, ready back.
interface net_cmd_sequencer_if;
    import net_cmd_sequencer_pkg::*;

    logic                   net_valid_i;
    logic [2:0]             net_cmd_i;
    logic [DMEM_ADDR_W-1:0] net_addr_i;
    logic [DATA_W-1:0]      net_data_i;
    logic                   net_ready_o;

    modport master (
        output net_valid_i, net_cmd_i, net_addr_i, net_data_i,
        input  net_ready_o
    );

    modport slave (
        input  net_valid_i, net_cmd_i, net_addr_i, net_data_i,
        output net_ready_o
    );

endinterface

// File: rtl/net_cmd_sequencer_fifo.sv
// Registered command FIFO (net_cmd_fifo); DEPTH must be a power of two so pointers wrap naturally.
module net_cmd_fifo
    import net_cmd_sequencer_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  net_cmd_s         data_i,
    input  logic             pop_i,
    output net_cmd_s         head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    net_cmd_s         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: storage is deliberately not reset; the count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/net_cmd_sequencer.sv
// Sequences buffered network commands onto imem/dmem/PC with core-priority dmem arbitration.
// Define NET_CMD_STATS_EN to add saturating issue/drop/preemption counters.
module net_cmd_sequencer
    import net_cmd_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    net_cmd_sequencer_if.slave     net_if,
    input  state_e                 state_i,
    input  logic                   core_dmem_req_i,
    output logic                   core_stall_o,
    output logic                   imem_we_o,
    output logic [IMEM_ADDR_W-1:0] imem_addr_o,
    output logic [DATA_W-1:0]      imem_wdata_o,
    output logic                   dmem_we_o,
    output logic [DMEM_ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0]      dmem_wdata_o,
    output logic                   pc_write_o,
    output logic [DATA_W-1:0]      pc_o,
`ifdef NET_CMD_STATS_EN
    output logic [15:0]            stat_issued_o,
    output logic [15:0]            stat_dropped_o,
    output logic [15:0]            stat_preempt_o,
`endif
    output logic                   drop_o
);
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    seq_state_e             state_q, state_d;
    logic [STARVE_W-1:0]    starve_q, starve_d;
    net_cmd_s               push_cmd, head;
    logic                   push, pop, fifo_full, fifo_empty, last_entry;
    logic [CNT_W-1:0]       fifo_count;
    logic                   imem_we_q, imem_we_d, dmem_we_q, dmem_we_d;
    logic                   pc_write_q, pc_write_d, drop_q, drop_d;
    logic [IMEM_ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [DMEM_ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0]      imem_wdata_q, imem_wdata_d, dmem_wdata_q, dmem_wdata_d, pc_q, pc_d;

    assign net_if.net_ready_o = !fifo_full;
    assign push       = net_if.net_valid_i && !fifo_full;
    assign push_cmd   = '{cmd: net_if.net_cmd_i, addr: net_if.net_addr_i, data: net_if.net_data_i};
    assign last_entry = (fifo_count == CNT_W'(1));

    net_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (push_cmd),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        // NOTE: every value written here gets a default first so no path can infer a latch.
        state_d      = state_q;
        starve_d     = starve_q;
        pop          = 1'b0;
        core_stall_o = 1'b0;
        imem_we_d    = 1'b0;
        imem_addr_d  = '0;
        imem_wdata_d = '0;
        dmem_we_d    = 1'b0;
        dmem_addr_d  = '0;
        dmem_wdata_d = '0;
        pc_write_d   = 1'b0;
        pc_d         = '0;
        drop_d       = 1'b0;

        case (state_q)
            S_ISSUE, S_BLOCK: begin
                case (head.cmd)
                    CMD_NOP: pop = 1'b1;
                    CMD_IMEM_WR: begin
                        if (state_i != RUN) begin
                            pop          = 1'b1;
                            imem_we_d    = 1'b1;
                            imem_addr_d  = head.addr[IMEM_ADDR_W-1:0];
                            imem_wdata_d = head.data;
                        end
                    end
                    CMD_DMEM_WR: begin
                        // The core owns the port while it runs, until the starvation limit forces a preemption.
                        if (state_i != RUN || !core_dmem_req_i || starve_q == STARVE_W'(STARVE_LIMIT)) begin
                            pop          = 1'b1;
                            dmem_we_d    = 1'b1;
                            dmem_addr_d  = head.addr;
                            dmem_wdata_d = head.data;
                            starve_d     = '0;
                            core_stall_o = (state_i == RUN) && core_dmem_req_i;
                        end else begin
                            starve_d = starve_q + STARVE_W'(1);
                        end
                    end
                    CMD_PC_WR: begin
                        // state_i reacts a cycle late, so a strobe right after another one is held back.
                        if (state_i == ERR) begin
                            pop    = 1'b1;
                            drop_d = 1'b1;
                        end else if (state_i == IDLE && !pc_write_q) begin
                            pop        = 1'b1;
                            pc_write_d = 1'b1;
                            pc_d       = head.data;
                        end
                    end
                    default: begin
                        pop    = 1'b1;
                        drop_d = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase

        if ((fifo_empty && !push) || (last_entry && pop && !push)) state_d = S_EMPTY;
        else if (state_q != S_EMPTY && !pop)                          state_d = S_BLOCK;
        else                                                          state_d = S_ISSUE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_EMPTY;
            starve_q     <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            pc_write_q   <= 1'b0;
            pc_q         <= '0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            pc_write_q   <= pc_write_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
        end
    end

    assign imem_we_o    = imem_we_q;
    assign imem_addr_o  = imem_addr_q;
    assign imem_wdata_o = imem_wdata_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_wdata_o = dmem_wdata_q;
    assign pc_write_o   = pc_write_q;
    assign pc_o         = pc_q;
    assign drop_o       = drop_q;

`ifdef NET_CMD_STATS_EN
    logic [15:0] stat_issued_q, stat_dropped_q, stat_preempt_q;
    logic        issue;

    assign issue = imem_we_d || dmem_we_d || pc_write_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_issued_q  <= '0;
            stat_dropped_q <= '0;
            stat_preempt_q <= '0;
        end else begin
            if (issue && stat_issued_q != 16'hFFFF)         stat_issued_q  <= stat_issued_q + 16'd1;
            if (drop_d && stat_dropped_q != 16'hFFFF)       stat_dropped_q <= stat_dropped_q + 16'd1;
            if (core_stall_o && stat_preempt_q != 16'hFFFF) stat_preempt_q <= stat_preempt_q + 16'd1;
        end
    end

    assign stat_issued_o  = stat_issued_q;
    assign stat_dropped_o = stat_dropped_q;
    assign stat_preempt_o = stat_preempt_q;
`endif

endmodule

// File: tb/tb_net_cmd_sequencer.sv
// Bench for net_cmd_sequencer: directed and random traffic scored against a queue-based reference model.
module tb_net_cmd_sequencer;
    import net_cmd_sequencer_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    typedef struct { logic [2:0] cmd; logic [9:0] addr; logic [31:0] data; } cmd_t;
    // kind: 1 imem write, 2 dmem write, 3 PC write, 4 drop
    typedef struct { int kind; logic [31:0] addr; logic [31:0] data; int cyc; } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    state_e      state_i;
    logic        core_dmem_req_i;
    logic        core_stall_o;
    logic        imem_we_o, dmem_we_o, pc_write_o, drop_o;
    logic [9:0]  imem_addr_o, dmem_addr_o;
    logic [31:0] imem_wdata_o, dmem_wdata_o, pc_o;
`ifdef NET_CMD_STATS_EN
    logic [15:0] stat_issued_o, stat_dropped_o, stat_preempt_o;
`endif

    net_cmd_sequencer_if net_if ();

    net_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk             (clk),
        .reset           (reset),
        .net_if          (net_if),
        .state_i         (state_i),
        .core_dmem_req_i (core_dmem_req_i),
        .core_stall_o    (core_stall_o),
        .imem_we_o       (imem_we_o),
        .imem_addr_o     (imem_addr_o),
        .imem_wdata_o    (imem_wdata_o),
        .dmem_we_o       (dmem_we_o),
        .dmem_addr_o     (dmem_addr_o),
        .dmem_wdata_o    (dmem_wdata_o),
        .pc_write_o      (pc_write_o),
        .pc_o            (pc_o),
`ifdef NET_CMD_STATS_EN
        .stat_issued_o   (stat_issued_o),
        .stat_dropped_o  (stat_dropped_o),
        .stat_preempt_o  (stat_preempt_o),
`endif
        .drop_o          (drop_o)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    cmd_t mq[$];
    ev_t  exp_q[$];
    int   stall_q[$];
    int   starve = 0;
    bit   pc_prev = 0;
    int   m_issued = 0, m_dropped = 0, m_preempt = 0;
    state_e cur_st = IDLE;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_ev(input int kind, input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back('{kind, a, d, cyc + 1});
        if (kind == 4) m_dropped++;
        else           m_issued++;
    endfunction

    // Reference model: decide what happens to the queue head this cycle from the command rules.
    function automatic void model_cycle(input state_e st, input logic req);
        bit   deq = 0;
        bit   pc_now = 0;
        cmd_t h;
        if (mq.size() > 0) begin
            h = mq[0];
            case (h.cmd)
                3'd0: deq = 1;
                3'd1: if (st != RUN) begin deq = 1; push_ev(1, 32'(h.addr), h.data); end
                3'd2: begin
                    if (st != RUN || !req) begin
                        deq = 1; starve = 0; push_ev(2, 32'(h.addr), h.data);
                    end else if (starve == LIMIT) begin
                        deq = 1; starve = 0; push_ev(2, 32'(h.addr), h.data);
                        stall_q.push_back(cyc); m_preempt++;
                    end else begin
                        starve++;
                    end
                end
                3'd3: begin
                    if (st == ERR) begin
                        deq = 1; push_ev(4, 0, 0);
                    end else if (st == IDLE && !pc_prev) begin
                        deq = 1; pc_now = 1; push_ev(3, 0, h.data);
                    end
                end
                default: begin deq = 1; push_ev(4, 0, 0); end
            endcase
            if (deq) void'(mq.pop_front());
        end
        pc_prev = pc_now;
    endfunction

    task automatic step(input logic v, input logic [2:0] c, input logic [9:0] a,
                        input logic [31:0] d, input state_e st, input logic req);
        bit can_accept;
        @(posedge clk);
        #1;
        net_if.net_valid_i = v;
        net_if.net_cmd_i   = c;
        net_if.net_addr_i  = a;
        net_if.net_data_i  = d;
        state_i            = st;
        core_dmem_req_i    = req;
        #1;
        can_accept = (mq.size() < DEPTH);
        check("net_ready", net_if.net_ready_o, can_accept);
        model_cycle(st, req);
        if (v && can_accept) mq.push_back('{c, a, d});
    endtask

    task automatic idle(input int n, input state_e st, input logic req);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 10'd0, 32'd0, st, req);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_imem_we"}, imem_we_o, 0);
        check({tag, "_imem_addr"}, imem_addr_o, 0);
        check({tag, "_imem_wdata"}, imem_wdata_o, 0);
        check({tag, "_dmem_we"}, dmem_we_o, 0);
        check({tag, "_dmem_addr"}, dmem_addr_o, 0);
        check({tag, "_dmem_wdata"}, dmem_wdata_o, 0);
        check({tag, "_pc_write"}, pc_write_o, 0);
        check({tag, "_pc"}, pc_o, 0);
        check({tag, "_drop"}, drop_o, 0);
        check({tag, "_core_stall"}, core_stall_o, 0);
        check({tag, "_net_ready"}, net_if.net_ready_o, 1);
    endtask

    task automatic reset_mid();
        #1;
        reset = 1'b1;
        net_if.net_valid_i = 1'b0;
        #1;
        check_quiet("mid_reset");
        while (exp_q.size() > 0 && exp_q[$].cyc >= cyc) void'(exp_q.pop_back());
        while (stall_q.size() > 0 && stall_q[$] >= cyc) void'(stall_q.pop_back());
        mq.delete();
        starve = 0; pc_prev = 0;
        m_issued = 0; m_dropped = 0; m_preempt = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every strobe the DUT presents is matched against the next expected event.
    always @(negedge clk) begin : monitor
        ev_t act, e;
        int  n;
        bit  pc_seen;
        n = int'(imem_we_o) + int'(dmem_we_o) + int'(pc_write_o) + int'(drop_o);
        if (n > 1) check("single_strobe", 64'(n), 1);
        if (n >= 1) begin
            if (imem_we_o)       act = '{1, 32'(imem_addr_o), imem_wdata_o, cyc};
            else if (dmem_we_o)  act = '{2, 32'(dmem_addr_o), dmem_wdata_o, cyc};
            else if (pc_write_o) act = '{3, 0, pc_o, cyc};
            else                 act = '{4, 0, 0, cyc};
            if (exp_q.size() == 0) begin
                check("unexpected_strobe_kind", 64'(act.kind), 0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", 64'(act.kind), 64'(e.kind));
                check("strobe_cycle", 64'(act.cyc), 64'(e.cyc));
                if (e.kind == 1 || e.kind == 2) check("strobe_addr", act.addr, e.addr);
                if (e.kind != 4) check("strobe_data", act.data, e.data);
            end
        end
        if (core_stall_o) begin
            if (stall_q.size() == 0) check("unexpected_stall", 1, 0);
            else                     check("stall_cycle", 64'(cyc), 64'(stall_q.pop_front()));
        end
        if (pc_write_o && pc_seen) check("pc_back_to_back", 1, 0);
        pc_seen = pc_write_o;
    end

    initial begin
        reset              = 1'b1;
        state_i            = IDLE;
        core_dmem_req_i    = 1'b0;
        net_if.net_valid_i = 1'b0;
        net_if.net_cmd_i   = 3'd0;
        net_if.net_addr_i  = '0;
        net_if.net_data_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        reset = 1'b0;

        // Single imem write in IDLE
        step(1'b1, CMD_IMEM_WR, 10'd5, 32'hDEAD_BEEF, IDLE, 1'b0);
        idle(4, IDLE, 1'b0);

        // Fill the buffer behind a blocked imem write
        for (int i = 0; i < 5; i++) step(1'b1, CMD_IMEM_WR, 10'(20 + i), $urandom, RUN, 1'b0);
        idle(2, RUN, 1'b0);
        idle(6, IDLE, 1'b0);

        // Two dmem writes starved by the core, each preempting
        step(1'b1, CMD_DMEM_WR, 10'd7, 32'h1111_0007, RUN, 1'b1);
        step(1'b1, CMD_DMEM_WR, 10'd8, 32'h2222_0008, RUN, 1'b1);
        idle(22, RUN, 1'b1);
        idle(2, IDLE, 1'b0);

        // PC write held during RUN, issued once the core is IDLE
        step(1'b1, CMD_PC_WR, 10'd0, 32'h0000_0040, RUN, 1'b0);
        idle(3, RUN, 1'b0);
        idle(4, IDLE, 1'b0);

        // Drops in ERR
        step(1'b1, CMD_PC_WR, 10'd0, 32'h0000_0080, ERR, 1'b0);
        step(1'b1, 3'd6, 10'd3, 32'h0000_0006, ERR, 1'b0);
        idle(4, ERR, 1'b0);
`ifdef NET_CMD_STATS_EN
        check("stat_dropped", stat_dropped_o, 64'(m_dropped));
`endif
        idle(2, IDLE, 1'b0);

        // Reset with three queued commands and a write on the port
        for (int i = 0; i < 4; i++) step(1'b1, CMD_IMEM_WR, 10'(40 + i), $urandom, RUN, 1'b0);
        step(1'b0, 3'd0, 10'd0, 32'd0, IDLE, 1'b0);
        step(1'b0, 3'd0, 10'd0, 32'd0, RUN, 1'b0);
        check("pre_reset_imem_we", imem_we_o, 1);
        reset_mid();
        idle(6, IDLE, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int         r;
            logic [2:0] op;
            r = $urandom_range(0, 9);
            if (r == 0)      op = 3'd0;
            else if (r < 4)  op = 3'd1;
            else if (r < 7)  op = 3'd2;
            else if (r < 9)  op = 3'd3;
            else             op = 3'(4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) cur_st = state_e'($urandom_range(0, 2));
            step(1'($urandom_range(0, 2) != 0), op, 10'($urandom_range(0, 1023)), $urandom,
                 cur_st, 1'($urandom_range(0, 9) < 8));
        end

        idle(30, IDLE, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("expected_strobes_left", 64'(exp_q.size()), 0);
        check("expected_stalls_left", 64'(stall_q.size()), 0);
`ifdef NET_CMD_STATS_EN
        check("stat_issued", stat_issued_o, 64'(m_issued));
        check("stat_dropped_end", stat_dropped_o, 64'(m_dropped));
        check("stat_preempt", stat_preempt_o, 64'(m_preempt));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
